// File: rtl/mul4_fitness_scorer_pkg.sv
// Shared types and helpers for the 2x2-bit multiplier fitness scorer.
package mul4_score_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } scorer_state_t;

    // Width needed to hold a perfect score over all batches without overflow.
    function automatic int score_width(input int lanes, input int num_batches);
        return $clog2(4 * lanes * num_batches + 1);
    endfunction

    // Golden 4-bit product of one lane, returned as {p3,p2,p1,p0}.
    function automatic logic [3:0] golden_prod(input logic a1, input logic a0,
                                               input logic b1, input logic b0);
        logic p0, p1, p2, p3;
        p0 = a0 & b0;
        p1 = (a1 & b0) ^ (a0 & b1);
        p2 = a1 & b1 & ~(a0 & b0);
        p3 = a1 & a0 & b1 & b0;
        return {p3, p2, p1, p0};
    endfunction

endpackage

// File: rtl/mul4_fitness_scorer_if.sv
// Batch-in / score-out handshake bundle for the fitness scorer.
interface mul4_fitness_scorer_if
    import mul4_score_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int NUM_BATCHES = 1
);
    localparam int SCORE_W = score_width(LANES, NUM_BATCHES);

    logic               in_valid;
    logic               in_ready;
    logic [LANES-1:0]   a1, a0, b1, b0;
    logic [LANES-1:0]   y3, y2, y1, y0;
    logic               out_valid;
    logic               out_ready;
    logic [SCORE_W-1:0] out_score;
    logic               out_perfect;

    modport master (
        output in_valid, a1, a0, b1, b0, y3, y2, y1, y0, out_ready,
        input  in_ready, out_valid, out_score, out_perfect
    );

    modport slave (
        input  in_valid, a1, a0, b1, b0, y3, y2, y1, y0, out_ready,
        output in_ready, out_valid, out_score, out_perfect
    );

endinterface

// File: rtl/mul4_fitness_scorer_match_popcount.sv
// Combinational popcount of the 4*LANES match vector as a binary adder tree.
// Leaves are per-lane 4-bit counts; node n sums children 2n+1 and 2n+2.
module mul4_match_popcount #(
    parameter  int LANES = 16,
    localparam int CNT_W = $clog2(4 * LANES + 1)
) (
    input  logic [4*LANES-1:0] match,
    output logic [CNT_W-1:0]   count
);

    logic [CNT_W-1:0] node [2*LANES-1];

    // Fill leaves with lane counts, then reduce bottom-up to the root.
    always_comb begin
        for (int n = 0; n < 2*LANES-1; n++) node[n] = '0;
        for (int i = 0; i < LANES; i++) begin
            node[LANES-1+i] = CNT_W'(match[i])         + CNT_W'(match[LANES+i])
                            + CNT_W'(match[2*LANES+i]) + CNT_W'(match[3*LANES+i]);
        end
        for (int n = LANES-2; n >= 0; n--) begin
            node[n] = node[2*n+1] + node[2*n+2];
        end
    end

    assign count = node[0];

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer: compares candidate 2x2 products against golden per lane,
// accumulates matching bits over NUM_BATCHES batches and reports one score.
//
//  state  | meaning
//  ACCUM  | accepting batches, one per cycle
//  DRAIN  | last batch in flight through S1/S2, score being registered
//  REPORT | score valid, waiting for consumer
module mul4_fitness_scorer
    import mul4_score_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int NUM_BATCHES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul4_fitness_scorer_if.slave  bus
);

    localparam int SCORE_W = score_width(LANES, NUM_BATCHES);
    localparam int POP_W   = $clog2(4 * LANES + 1);
    localparam int CNT_W   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(4 * LANES * NUM_BATCHES);
    localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_BATCHES - 1);

    scorer_state_t      state, state_nxt;
    logic               in_ready, out_valid, accept, report_hs, last_accept;
    logic [4*LANES-1:0] match, s1_match;
    logic               s1_valid, s1_last, s2_last;
    logic [CNT_W-1:0]   batch_cnt;
    logic [POP_W-1:0]   pop;
    logic [SCORE_W-1:0] acc, out_score;
    logic               out_perfect;

    assign accept      = bus.in_valid & in_ready;
    assign report_hs   = out_valid & bus.out_ready;
    assign last_accept = accept & (batch_cnt == LAST_IDX);

    // Per-lane match bits, grouped as {bit3 lanes, bit2 lanes, bit1 lanes, bit0 lanes}.
    always_comb begin
        logic [3:0] prod;
        prod  = '0;
        match = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = golden_prod(bus.a1[i], bus.a0[i], bus.b1[i], bus.b0[i]);
            match[i]         = ~(bus.y0[i] ^ prod[0]);
            match[LANES+i]   = ~(bus.y1[i] ^ prod[1]);
            match[2*LANES+i] = ~(bus.y2[i] ^ prod[2]);
            match[3*LANES+i] = ~(bus.y3[i] ^ prod[3]);
        end
    end

    mul4_match_popcount #(.LANES(LANES)) u_popcount (
        .match (s1_match),
        .count (pop)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Next-state: leave ACCUM on the final batch, report once S2 has folded it in.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_accept)    state_nxt = DRAIN;
            DRAIN:   if (s2_last)        state_nxt = REPORT;
            REPORT:  if (bus.out_ready)  state_nxt = ACCUM;
            default:                     state_nxt = ACCUM;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == REPORT);
    end

    // Batch counter wraps on the final batch of an evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           batch_cnt <= '0;
        else if (last_accept) batch_cnt <= '0;
        else if (accept)      batch_cnt <= batch_cnt + CNT_W'(1);
    end

    // S1: capture match vector and last-batch flag on each accepted batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_match <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last  <= (batch_cnt == LAST_IDX);
                s1_match <= match;
            end
        end
    end

    // S2: fold popcount into the accumulator; cleared once the score is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_valid & s1_last;
            if (report_hs)     acc <= '0;
            else if (s1_valid) acc <= acc + SCORE_W'(pop);
        end
    end

    // Score register, loaded once the final batch is in the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_score   <= '0;
            out_perfect <= 1'b0;
        end else if (state == DRAIN && s2_last) begin
            out_score   <= acc;
            out_perfect <= (acc == FULL_SCORE);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_score   = out_score;
    assign bus.out_perfect = out_perfect;

endmodule
